matrix_uart_host: RTL and testbench

Host-side sequencer for the UART matrix-multiply link. It sends the frame that the accelerator's UART front end expects: one sync byte, then matrix A, then matrix B, each row-major with N*N bytes. It then collects the N*N result bytes that come back. It sits between a local operand memory and a byte-level UART transmitter/receiver pair, and is used both as the system-level driver and as the bench-side stimulus engine.

---
 rtl/matrix_uart_host_pkg.sv | 41 ++++
 rtl/matrix_uart_host_if.sv | 55 +++++
 rtl/matrix_uart_host_timer.sv | 40 ++++
 rtl/matrix_uart_host.sv | 222 ++++++++++++++++++++++
 tb/tb_matrix_uart_host.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_uart_host_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_link_pkg
// Purpose  : Definitions shared by both ends of the UART matrix-multiply link.
//            It holds the sequencer state type, the legal range for the
//            matrix size N, the frame sync byte and the element index width.
//            It also provides a helper that turns N into the element count
//            N*N.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package matrix_link_pkg;

    localparam int unsigned MATRIX_SIZE_MIN_DEF = 3;
    localparam int unsigned MATRIX_SIZE_MAX_DEF = 10;
    localparam logic [7:0]  SYNC_BYTE_DEF       = 8'hA5;

    // Wide enough for an element index of the largest legal matrix (0..99).
    localparam int unsigned ELEM_IDX_W = $clog2(MATRIX_SIZE_MAX_DEF * MATRIX_SIZE_MAX_DEF);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_FETCH = 3'd2,
        ST_LOAD  = 3'd3,
        ST_SEND  = 3'd4,
        ST_RECV  = 3'd5,
        ST_DONE  = 3'd6
    } link_state_t;

    // N*N. The product is formed at 8 bits so that it cannot overflow for any
    // 4-bit N. The result is then cut to the index width. Only legal N
    // (at most 10) reaches this helper, so the cut loses nothing.
    function automatic logic [ELEM_IDX_W-1:0] elem_count(input logic [3:0] n);
        logic [7:0] w_sq;
        w_sq = {4'd0, n} * {4'd0, n};
        return w_sq[ELEM_IDX_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_uart_host_if.sv
`default_nettype none
// ============================================================================
// Module   : matrix_uart_host_if
// Purpose  : Bundles the bus signals of the link host into one interface.
//            It covers three groups: operand-memory read, UART byte
//            transmit/receive, and result-memory write.
// Modports : master - the host sequencer
//            slave  - the environment (operand memory, UART pair, result sink)
// Signals  : op_rd_en/op_sel/op_addr -> op_rd_data (1-cycle read latency)
//            tx_data/tx_valid <- tx_ready (valid/ready byte handshake)
//            rx_data/rx_valid (1-cycle strobe)
//            res_we/res_addr/res_data
// Revision : 1.0 - initial release
// ============================================================================
interface matrix_uart_host_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    import matrix_link_pkg::*;

    logic                  op_rd_en;
    logic                  op_sel;
    logic [ELEM_IDX_W-1:0] op_addr;
    logic [DATA_WIDTH-1:0] op_rd_data;

    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;

    logic                  res_we;
    logic [ELEM_IDX_W-1:0] res_addr;
    logic [DATA_WIDTH-1:0] res_data;

    modport master (
        output op_rd_en, op_sel, op_addr,
        input  op_rd_data,
        output tx_data, tx_valid,
        input  tx_ready,
        input  rx_data, rx_valid,
        output res_we, res_addr, res_data
    );

    modport slave (
        input  op_rd_en, op_sel, op_addr,
        output op_rd_data,
        input  tx_data, tx_valid,
        output tx_ready,
        output rx_data, rx_valid,
        input  res_we, res_addr, res_data
    );

endinterface
`default_nettype wire

// File: rtl/matrix_uart_host_timer.sv
`default_nettype none
// ============================================================================
// Module   : link_timeout_timer
// Purpose  : Counts idle cycles. The counter saturates at TIMEOUT_CYCLES-1.
//            expire is high while the count sits at that value.
// Ports    : clk, rst_n (async, active-low)
//            clear  - forces the count to zero (has priority over enable)
//            enable - advances the count by one per cycle
//            expire - count == TIMEOUT_CYCLES-1
// Revision : 1.0 - initial release
// ============================================================================
module link_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != C_LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expire = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/matrix_uart_host.sv
`default_nettype none
// ============================================================================
// Module   : matrix_uart_host
// Purpose  : Host-side sequencer for the UART matrix-multiply link.
//            It transmits the frame SYNC_BYTE, then A[0..N*N-1], then
//            B[0..N*N-1], with each matrix row-major. It then collects N*N
//            result bytes into the result memory. A watchdog limits the gap
//            between result bytes.
// Ports    : clk, rst_n (async, active-low)
//            start/abort/matrix_size     - transaction control
//            busy/done/err_size/err_timeout/rx_unexpected - status
//            bus (matrix_uart_host_if.master) - operand read, UART tx/rx,
//                                               result write
// Revision : 1.0 - initial release
// ============================================================================
module matrix_uart_host
    import matrix_link_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned MATRIX_SIZE_MIN = MATRIX_SIZE_MIN_DEF,
    parameter int unsigned MATRIX_SIZE_MAX = MATRIX_SIZE_MAX_DEF,
    parameter logic [7:0]  SYNC_BYTE       = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYCLES  = 1_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [3:0]          matrix_size,
    output logic                busy,
    output logic                done,
    output logic                err_size,
    output logic                err_timeout,
    output logic                rx_unexpected,
    matrix_uart_host_if.master  bus
);

    link_state_t           r_state;
    logic [ELEM_IDX_W-1:0] r_idx;
    logic [ELEM_IDX_W-1:0] r_n_elems;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_valid;
    logic                  r_op_rd_en;
    logic                  r_op_sel;
    logic [ELEM_IDX_W-1:0] r_op_addr;
    logic                  r_done;
    logic                  r_err_size;
    logic                  r_err_timeout;
    logic                  r_rx_unexp;

    logic w_tx_fire;
    logic w_last_idx;
    logic w_size_ok;
    logic w_rx_stray;
    logic w_timer_clear;
    logic w_timer_en;
    logic w_timer_expire;

    assign w_tx_fire  = r_tx_valid && bus.tx_ready;
    assign w_last_idx = (r_idx == (r_n_elems - ELEM_IDX_W'(1)));
    assign w_size_ok  = (32'(matrix_size) >= MATRIX_SIZE_MIN) &&
                        (32'(matrix_size) <= MATRIX_SIZE_MAX);
    // A received byte counts only in RECV. Anywhere else it is dropped and flagged.
    assign w_rx_stray = bus.rx_valid && (r_state != ST_RECV);

    // The timer counts only the silent cycles of RECV. It restarts on every
    // received byte and is held at zero in every other state.
    assign w_timer_clear = (r_state != ST_RECV) || bus.rx_valid || abort;
    assign w_timer_en    = (r_state == ST_RECV);

    link_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_timer_clear),
        .enable (w_timer_en),
        .expire (w_timer_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_n_elems     <= '0;
            r_tx_data     <= '0;
            r_tx_valid    <= 1'b0;
            r_op_rd_en    <= 1'b0;
            r_op_sel      <= 1'b0;
            r_op_addr     <= '0;
            r_done        <= 1'b0;
            r_err_size    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_rx_unexp    <= 1'b0;
        end else begin
            // Strobes are one cycle wide unless a state re-asserts them.
            r_done        <= 1'b0;
            r_err_size    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_op_rd_en    <= 1'b0;

            if (abort) begin
                r_state    <= ST_IDLE;
                r_tx_valid <= 1'b0;
                r_idx      <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            if (w_size_ok) begin
                                r_n_elems  <= elem_count(matrix_size);
                                r_idx      <= '0;
                                r_op_sel   <= 1'b0;
                                r_op_addr  <= '0;
                                r_rx_unexp <= 1'b0;
                                r_tx_data  <= DATA_WIDTH'(SYNC_BYTE);
                                r_tx_valid <= 1'b1;
                                r_state    <= ST_SYNC;
                            end else begin
                                r_err_size <= 1'b1;
                            end
                        end
                    end

                    ST_SYNC: begin
                        if (w_tx_fire) begin
                            r_tx_valid <= 1'b0;
                            r_op_sel   <= 1'b0;
                            r_idx      <= '0;
                            r_op_addr  <= '0;
                            r_op_rd_en <= 1'b1;
                            r_state    <= ST_FETCH;
                        end
                    end

                    // The read strobe is already on the bus for this cycle,
                    // so the data arrives while the FSM is in LOAD.
                    ST_FETCH: begin
                        r_state <= ST_LOAD;
                    end

                    ST_LOAD: begin
                        r_tx_data  <= bus.op_rd_data;
                        r_tx_valid <= 1'b1;
                        r_state    <= ST_SEND;
                    end

                    ST_SEND: begin
                        if (w_tx_fire) begin
                            r_tx_valid <= 1'b0;
                            if (!w_last_idx) begin
                                r_idx      <= r_idx + ELEM_IDX_W'(1);
                                r_op_addr  <= r_idx + ELEM_IDX_W'(1);
                                r_op_rd_en <= 1'b1;
                                r_state    <= ST_FETCH;
                            end else if (!r_op_sel) begin
                                r_op_sel   <= 1'b1;
                                r_idx      <= '0;
                                r_op_addr  <= '0;
                                r_op_rd_en <= 1'b1;
                                r_state    <= ST_FETCH;
                            end else begin
                                r_idx   <= '0;
                                r_state <= ST_RECV;
                            end
                        end
                    end

                    ST_RECV: begin
                        if (bus.rx_valid) begin
                            if (w_last_idx) begin
                                r_done  <= 1'b1;
                                r_idx   <= '0;
                                r_state <= ST_DONE;
                            end else begin
                                r_idx <= r_idx + ELEM_IDX_W'(1);
                            end
                        end else if (w_timer_expire) begin
                            r_err_timeout <= 1'b1;
                            r_idx         <= '0;
                            r_state       <= ST_IDLE;
                        end
                    end

                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end

            // This assignment comes last on purpose. A stray byte that lands
            // on the same cycle as an accepted start still leaves the flag set.
            if (w_rx_stray) begin
                r_rx_unexp <= 1'b1;
            end
        end
    end

    // The result write is aligned with the receive strobe. The address is
    // the element count so far.
    assign bus.res_we   = (r_state == ST_RECV) && bus.rx_valid && !abort;
    assign bus.res_addr = r_idx;
    assign bus.res_data = bus.rx_data;

    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = r_tx_valid;
    assign bus.op_rd_en = r_op_rd_en;
    assign bus.op_sel   = r_op_sel;
    assign bus.op_addr  = r_op_addr;

    assign busy          = (r_state != ST_IDLE);
    assign done          = r_done;
    assign err_size      = r_err_size;
    assign err_timeout   = r_err_timeout;
    assign rx_unexpected = r_rx_unexp;

endmodule
`default_nettype wire

// File: tb/tb_matrix_uart_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_uart_host
// Purpose  : Self-checking bench for matrix_uart_host. The operand memory is
//            a one-cycle-latency array model. The expected byte stream and
//            results are built from the frame definition (sync, A, B, then
//            N*N results).
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_uart_host;
    import matrix_link_pkg::*;

    localparam int unsigned TO = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] matrix_size = 4'd0;
    logic       busy, done, err_size, err_timeout, rx_unexpected;

    matrix_uart_host_if #(.DATA_WIDTH(8)) bus ();

    matrix_uart_host #(
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .matrix_size   (matrix_size),
        .busy          (busy),
        .done          (done),
        .err_size      (err_size),
        .err_timeout   (err_timeout),
        .rx_unexpected (rx_unexpected),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // Operand memory (one-cycle read latency) and result expectations
    logic [7:0] mem_a   [128];
    logic [7:0] mem_b   [128];
    logic [7:0] res_exp [128];

    always @(posedge clk) begin
        if (bus.op_rd_en) bus.op_rd_data <= bus.op_sel ? mem_b[bus.op_addr] : mem_a[bus.op_addr];
    end

    // Edge monitor: transfer log, result writes, done pulses, tx stability
    logic [7:0] tx_log [$];
    int         tx_cyc [$];
    logic [7:0] res_mem [128];
    int         cyc = 0;
    int         res_cnt = 0;
    int         done_cnt = 0;
    int         stab_err = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.tx_valid && bus.tx_ready) begin
            tx_log.push_back(bus.tx_data);
            tx_cyc.push_back(cyc);
        end
        if (bus.res_we) begin
            res_mem[bus.res_addr] = bus.res_data;
            res_cnt = res_cnt + 1;
        end
        if (done) done_cnt = done_cnt + 1;
        if (prev_hold && bus.tx_valid && (bus.tx_data !== prev_data)) stab_err = stab_err + 1;
        prev_hold = bus.tx_valid && !bus.tx_ready && !abort && rst_n;
        prev_data = bus.tx_data;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        matrix_size = 4'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    // Drive tx_ready until the log holds 'target' entries. This is bounded.
    task automatic wait_tx(input int target, input bit rnd, input string tag);
        int guard;
        guard = 0;
        while (tx_log.size() < target && guard < 5000) begin
            bus.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            guard++;
        end
        bus.tx_ready = 1'b1;
        check({tag, "_bound"}, 32'(guard < 5000), 32'd1);
    endtask

    // Reference frame: sync byte, all of A, then all of B, both row-major
    task automatic check_seq(input int n, input int base, input string tag);
        logic [7:0] exp_q [$];
        int mism;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < n * n; i++) exp_q.push_back(mem_a[i]);
        for (int i = 0; i < n * n; i++) exp_q.push_back(mem_b[i]);
        check({tag, "_count"}, 32'(tx_log.size() - base), 32'(exp_q.size()));
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i >= tx_log.size() || tx_log[base + i] !== exp_q[i]) mism++;
        check({tag, "_bytes"}, 32'(mism), 32'd0);
    endtask

    task automatic return_results(input int cnt, input bit expect_done, input string tag);
        for (int i = 0; i < cnt; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = res_exp[i];
            @(negedge clk);
            bus.rx_valid = 1'b0;
            if (i == cnt - 1) begin
                check({tag, "_done_pulse"}, 32'(done), 32'(expect_done));
            end else begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
    endtask

    task automatic check_results(input int n, input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < n; i++) if (res_mem[i] !== res_exp[i]) mism++;
        check({tag, "_data"}, 32'(mism), 32'd0);
    endtask

    initial begin
        int base, rbase, dbase, hit, g;
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_status", {27'd0, done, err_size, err_timeout, rx_unexpected, bus.tx_valid}, 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_strobes", {30'd0, bus.op_rd_en, bus.res_we}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- N=3, A=1..9, B=identity, ready held high ----
        for (int i = 0; i < 9; i++) begin
            mem_a[i]   = 8'(i + 1);
            mem_b[i]   = (i % 4 == 0) ? 8'd1 : 8'd0;
            res_exp[i] = 8'(i + 1);
        end
        base = tx_log.size(); rbase = res_cnt; dbase = done_cnt;
        bus.tx_ready = 1'b1;
        do_start(3);
        check("n3_busy", 32'(busy), 32'd1);
        wait_tx(base + 19, 1'b0, "n3_tx");
        check("n3_rate", 32'(tx_cyc[base + 18] - tx_cyc[base]), 32'd54);
        return_results(9, 1'b1, "n3");
        check_seq(3, base, "n3_seq");
        check("n3_res_cnt", 32'(res_cnt - rbase), 32'd9);
        check_results(9, "n3_res");
        @(negedge clk);
        check("n3_idle", 32'(busy), 32'd0);
        check("n3_done_cnt", 32'(done_cnt - dbase), 32'd1);

        // ---- out-of-range sizes ----
        base = tx_log.size();
        do_start(2);
        check("n2_err_size", 32'(err_size), 32'd1);
        check("n2_busy", {30'd0, busy, bus.tx_valid}, 32'd0);
        @(negedge clk);
        check("n2_err_clear", 32'(err_size), 32'd0);
        do_start(11);
        check("n11_err_size", 32'(err_size), 32'd1);
        check("n11_busy", {30'd0, busy, bus.tx_valid}, 32'd0);
        repeat (3) @(negedge clk);
        check("nbad_no_tx", 32'(tx_log.size() - base), 32'd0);

        // ---- N=10, random data, random tx_ready ----
        for (int i = 0; i < 100; i++) begin
            mem_a[i]   = 8'($urandom);
            mem_b[i]   = 8'($urandom);
            res_exp[i] = 8'($urandom);
        end
        base = tx_log.size(); rbase = res_cnt; dbase = done_cnt;
        do_start(10);
        wait_tx(base + 201, 1'b1, "n10_tx");
        return_results(100, 1'b1, "n10");
        repeat (4) @(negedge clk);
        check_seq(10, base, "n10_seq");
        check("n10_stable", 32'(stab_err), 32'd0);
        check("n10_res_cnt", 32'(res_cnt - rbase), 32'd100);
        check_results(100, "n10_res");
        check("n10_done_cnt", 32'(done_cnt - dbase), 32'd1);

        // ---- timeout after 4 of 9 results ----
        for (int i = 0; i < 9; i++) begin
            mem_a[i] = 8'($urandom); mem_b[i] = 8'($urandom); res_exp[i] = 8'($urandom);
        end
        base = tx_log.size(); rbase = res_cnt; dbase = done_cnt;
        do_start(3);
        wait_tx(base + 19, 1'b0, "to_tx");
        return_results(4, 1'b0, "to");
        hit = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (err_timeout && hit == 0) hit = k;
        end
        check("to_latency", 32'(hit), TO);
        check("to_idle", 32'(busy), 32'd0);
        check("to_no_done", 32'(done_cnt - dbase), 32'd0);
        check("to_res_cnt", 32'(res_cnt - rbase), 32'd4);
        check_results(4, "to_res");

        // ---- abort while the 5th A byte is held by tx_ready=0 ----
        for (int i = 0; i < 9; i++) mem_a[i] = 8'($urandom);
        base = tx_log.size();
        do_start(3);
        g = 0;
        while (tx_log.size() < base + 5 && g < 200) begin @(negedge clk); g++; end
        bus.tx_ready = 1'b0;
        g = 0;
        while (!bus.tx_valid && g < 20) begin @(negedge clk); g++; end
        check("ab_hold_data", 32'(bus.tx_data), 32'(mem_a[4]));
        repeat (3) @(negedge clk);
        do_abort();
        check("ab_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_no_pulse", {30'd0, done, err_timeout}, 32'd0);
        check("ab_tx_count", 32'(tx_log.size() - base), 32'd5);
        base = tx_log.size();
        bus.tx_ready = 1'b1;
        do_start(3);
        g = 0;
        while (tx_log.size() <= base && g < 20) begin @(negedge clk); g++; end
        check("ab_resync", 32'((tx_log.size() > base) ? tx_log[base] : 8'h00), 32'h0000_00A5);

        // Asynchronous reset mid-transaction takes effect without a clock edge.
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", {29'd0, busy, bus.tx_valid, bus.op_rd_en}, 32'd0);
        check("arst_tx_data", 32'(bus.tx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- stray byte during SEND, then a normal completion ----
        for (int i = 0; i < 9; i++) begin
            mem_a[i] = 8'($urandom); mem_b[i] = 8'($urandom); res_exp[i] = 8'($urandom);
        end
        base = tx_log.size(); rbase = res_cnt;
        do_start(3);
        wait_tx(base + 3, 1'b0, "sr_pre");
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h5A;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        check("sr_flag_set", 32'(rx_unexpected), 32'd1);
        check("sr_no_write", 32'(res_cnt - rbase), 32'd0);
        wait_tx(base + 19, 1'b0, "sr_tx");
        return_results(9, 1'b1, "sr");
        check_seq(3, base, "sr_seq");
        check("sr_res_cnt", 32'(res_cnt - rbase), 32'd9);
        check_results(9, "sr_res");
        check("sr_flag_sticky", 32'(rx_unexpected), 32'd1);
        @(negedge clk);
        do_start(3);
        check("sr_flag_cleared", 32'(rx_unexpected), 32'd0);
        do_abort();
        check("sr_end_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
